// File: rtl/adxl_pkg.sv
// adxl_pkg: shared types, register/command constants and byte-table helpers
// for the ADXL362 acquisition sequencer.
// Optional build macro: ADXL_STATUS_READ_EN (adds a STATUS byte to every burst).
package adxl_pkg;

  localparam logic [7:0] ADXL_CMD_WRITE     = 8'h0A;
  localparam logic [7:0] ADXL_CMD_READ      = 8'h0B;
  localparam logic [7:0] ADXL_REG_POWER_CTL = 8'h2D;
  localparam logic [7:0] ADXL_REG_XDATA     = 8'h08;
  localparam logic [7:0] ADXL_REG_STATUS    = 8'h0B;

  typedef enum logic [3:0] {
    ST_STARTUP,
    ST_W_CMD,
    ST_W_ADDR,
    ST_W_DATA,
    ST_IDLE,
    ST_R_CMD,
    ST_R_ADDR,
    ST_R_X,
    ST_R_Y,
    ST_R_Z,
`ifdef ADXL_STATUS_READ_EN
    ST_R_STAT,
`endif
    ST_PUBLISH
  } adxl_state_e;

  // Each byte state runs an ISSUE phase (waiting for the controller) then a WAIT phase.
  typedef enum logic {
    PH_ISSUE,
    PH_WAIT
  } adxl_phase_e;

  // True for states that move one byte over SPI.
  function automatic logic is_byte_state(input adxl_state_e s);
    logic r;
    case (s)
      ST_W_CMD, ST_W_ADDR, ST_W_DATA,
      ST_R_CMD, ST_R_ADDR, ST_R_X, ST_R_Y, ST_R_Z: r = 1'b1;
`ifdef ADXL_STATUS_READ_EN
      ST_R_STAT: r = 1'b1;
`endif
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Byte placed on spi_tx while in state s. Data reads clock out zeros.
  function automatic logic [7:0] byte_tx(input adxl_state_e s, input logic [7:0] pwr_value);
    logic [7:0] b;
    case (s)
      ST_W_CMD:  b = ADXL_CMD_WRITE;
      ST_W_ADDR: b = ADXL_REG_POWER_CTL;
      ST_W_DATA: b = pwr_value;
      ST_R_CMD:  b = ADXL_CMD_READ;
      ST_R_ADDR: b = ADXL_REG_XDATA;
      default:   b = 8'h00;
    endcase
    return b;
  endfunction

  // Chip select stays asserted after every byte except the last of a transaction.
  function automatic logic byte_hold(input adxl_state_e s);
    logic h;
    case (s)
      ST_W_CMD, ST_W_ADDR,
      ST_R_CMD, ST_R_ADDR, ST_R_X, ST_R_Y: h = 1'b1;
`ifdef ADXL_STATUS_READ_EN
      ST_R_Z: h = 1'b1;
`endif
      default: h = 1'b0;
    endcase
    return h;
  endfunction

  // Successor of a byte state once its transfer completes.
  function automatic adxl_state_e next_byte_state(input adxl_state_e s);
    adxl_state_e n;
    case (s)
      ST_W_CMD:  n = ST_W_ADDR;
      ST_W_ADDR: n = ST_W_DATA;
      ST_W_DATA: n = ST_IDLE;
      ST_R_CMD:  n = ST_R_ADDR;
      ST_R_ADDR: n = ST_R_X;
      ST_R_X:    n = ST_R_Y;
      ST_R_Y:    n = ST_R_Z;
`ifdef ADXL_STATUS_READ_EN
      ST_R_Z:    n = ST_R_STAT;
      ST_R_STAT: n = ST_PUBLISH;
`else
      ST_R_Z:    n = ST_PUBLISH;
`endif
      default:   n = ST_STARTUP;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/adxl_sampler_rate_tick.sv
// rate_tick: free-running divider producing a registered one-cycle tick every
// CLK_FREQUENCY/RATE clocks while run is high; held at zero otherwise.
// Optional build macro of the enclosing design: ADXL_STATUS_READ_EN (no effect here).
module rate_tick #(
  parameter int unsigned CLK_FREQUENCY = 100_000_000,
  parameter int unsigned RATE          = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic tick
);

  localparam int unsigned PERIOD = (CLK_FREQUENCY / RATE > 0) ? CLK_FREQUENCY / RATE : 1;
  localparam int unsigned TERM   = PERIOD - 1;
  localparam int unsigned CW     = (TERM > 0) ? $clog2(TERM + 1) : 1;

  logic [CW-1:0] cnt_r;
  logic          tick_r;

  // Period counter; wraps at the terminal count and flags a tick there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r  <= '0;
      tick_r <= 1'b0;
    end else if (!run) begin
      cnt_r  <= '0;
      tick_r <= 1'b0;
    end else if (cnt_r == CW'(TERM)) begin
      cnt_r  <= '0;
      tick_r <= 1'b1;
    end else begin
      cnt_r  <= cnt_r + CW'(1);
      tick_r <= 1'b0;
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/adxl_sampler.sv
// adxl_sampler: autonomous ADXL362 acquisition sequencer. After a power-up delay
// it writes POWER_CTL, then periodically burst-reads XDATA/YDATA/ZDATA and
// publishes the three bytes together with a one-cycle valid strobe.
// Optional build macro: ADXL_STATUS_READ_EN appends a STATUS byte to each burst
// and exposes it on sample_status.
module adxl_sampler
  import adxl_pkg::*;
#(
  parameter int unsigned CLK_FREQUENCY   = 100_000_000,
  parameter int unsigned SAMPLE_RATE     = 100,
  parameter int unsigned STARTUP_CYCLES  = 500_000,
  parameter logic [7:0]  POWER_CTL_VALUE = 8'h02
) (
  input  logic       CLK100MHZ,
  input  logic       CPU_RESETN,
  input  logic       enable,
  input  logic       spi_busy,
  input  logic       spi_done,
  input  logic [7:0] spi_rx,
  output logic       spi_start,
  output logic [7:0] spi_tx,
  output logic       spi_hold_cs,
  output logic       init_done,
  output logic [7:0] sample_x,
  output logic [7:0] sample_y,
  output logic [7:0] sample_z,
  output logic       sample_valid,
  output logic       sample_missed
`ifdef ADXL_STATUS_READ_EN
  ,
  output logic [7:0] sample_status
`endif
);

  localparam logic [31:0] STARTUP_LAST = (STARTUP_CYCLES == 0) ? 32'd0 : 32'(STARTUP_CYCLES - 1);

  logic [1:0]  rst_sync_r;
  logic        rst_n_s;
  logic        run_s;
  logic        tick_s;

  adxl_state_e state_r, state_n;
  adxl_phase_e phase_r, phase_n;
  logic [31:0] startup_cnt_r, startup_cnt_n;
  logic [7:0]  shadow_x_r, shadow_x_n;
  logic [7:0]  shadow_y_r, shadow_y_n;
  logic [7:0]  shadow_z_r, shadow_z_n;

  logic        spi_start_r, spi_start_n;
  logic [7:0]  spi_tx_r, spi_tx_n;
  logic        spi_hold_cs_r, spi_hold_cs_n;
  logic        init_done_r, init_done_n;
  logic [7:0]  sample_x_r, sample_x_n;
  logic [7:0]  sample_y_r, sample_y_n;
  logic [7:0]  sample_z_r, sample_z_n;
  logic        sample_valid_r, sample_valid_n;
  logic        sample_missed_r, sample_missed_n;
`ifdef ADXL_STATUS_READ_EN
  logic [7:0]  shadow_s_r, shadow_s_n;
  logic [7:0]  sample_status_r, sample_status_n;
`endif

  // Reset synchroniser: assertion is immediate, release is aligned to the clock.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  assign rst_n_s = rst_sync_r[1];
  assign run_s   = init_done_r & enable;

  rate_tick #(
    .CLK_FREQUENCY(CLK_FREQUENCY),
    .RATE         (SAMPLE_RATE)
  ) u_rate_tick (
    .clk  (CLK100MHZ),
    .rst_n(rst_n_s),
    .run  (run_s),
    .tick (tick_s)
  );

  // Sequencer state and all registered outputs.
  always_ff @(posedge CLK100MHZ or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_r         <= ST_STARTUP;
      phase_r         <= PH_ISSUE;
      startup_cnt_r   <= 32'd0;
      shadow_x_r      <= 8'h00;
      shadow_y_r      <= 8'h00;
      shadow_z_r      <= 8'h00;
      spi_start_r     <= 1'b0;
      spi_tx_r        <= 8'h00;
      spi_hold_cs_r   <= 1'b0;
      init_done_r     <= 1'b0;
      sample_x_r      <= 8'h00;
      sample_y_r      <= 8'h00;
      sample_z_r      <= 8'h00;
      sample_valid_r  <= 1'b0;
      sample_missed_r <= 1'b0;
`ifdef ADXL_STATUS_READ_EN
      shadow_s_r      <= 8'h00;
      sample_status_r <= 8'h00;
`endif
    end else begin
      state_r         <= state_n;
      phase_r         <= phase_n;
      startup_cnt_r   <= startup_cnt_n;
      shadow_x_r      <= shadow_x_n;
      shadow_y_r      <= shadow_y_n;
      shadow_z_r      <= shadow_z_n;
      spi_start_r     <= spi_start_n;
      spi_tx_r        <= spi_tx_n;
      spi_hold_cs_r   <= spi_hold_cs_n;
      init_done_r     <= init_done_n;
      sample_x_r      <= sample_x_n;
      sample_y_r      <= sample_y_n;
      sample_z_r      <= sample_z_n;
      sample_valid_r  <= sample_valid_n;
      sample_missed_r <= sample_missed_n;
`ifdef ADXL_STATUS_READ_EN
      shadow_s_r      <= shadow_s_n;
      sample_status_r <= sample_status_n;
`endif
    end
  end

  // Next-state logic: startup delay, byte handshakes, shadow capture and publish.
  always_comb begin
    state_n         = state_r;
    phase_n         = phase_r;
    startup_cnt_n   = startup_cnt_r;
    shadow_x_n      = shadow_x_r;
    shadow_y_n      = shadow_y_r;
    shadow_z_n      = shadow_z_r;
    spi_start_n     = 1'b0;
    init_done_n     = init_done_r;
    sample_x_n      = sample_x_r;
    sample_y_n      = sample_y_r;
    sample_z_n      = sample_z_r;
    sample_valid_n  = 1'b0;
    // A tick that finds the sequencer busy is dropped, not queued.
    sample_missed_n = tick_s && (state_r != ST_IDLE);
`ifdef ADXL_STATUS_READ_EN
    shadow_s_n      = shadow_s_r;
    sample_status_n = sample_status_r;
`endif

    case (state_r)
      ST_STARTUP: begin
        if (startup_cnt_r >= STARTUP_LAST) begin
          state_n       = ST_W_CMD;
          phase_n       = PH_ISSUE;
          startup_cnt_n = 32'd0;
        end else begin
          startup_cnt_n = startup_cnt_r + 32'd1;
        end
      end
      ST_IDLE: begin
        if (tick_s && enable) begin
          state_n = ST_R_CMD;
          phase_n = PH_ISSUE;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_PUBLISH: begin
        state_n = ST_IDLE;
      end
      default: begin
        if (!is_byte_state(state_r)) begin
          state_n = ST_STARTUP;
          phase_n = PH_ISSUE;
        end else if (phase_r == PH_ISSUE) begin
          // Stray spi_done here is a protocol error and is deliberately ignored.
          if (!spi_busy) begin
            spi_start_n = 1'b1;
            phase_n     = PH_WAIT;
          end else begin
            phase_n     = PH_ISSUE;
          end
        end else if (spi_done) begin
          phase_n = PH_ISSUE;
          state_n = next_byte_state(state_r);
          case (state_r)
            ST_W_DATA: init_done_n = 1'b1;
            ST_R_X:    shadow_x_n  = spi_rx;
            ST_R_Y:    shadow_y_n  = spi_rx;
            ST_R_Z:    shadow_z_n  = spi_rx;
`ifdef ADXL_STATUS_READ_EN
            ST_R_STAT: shadow_s_n  = spi_rx;
`endif
            default:   init_done_n = init_done_r;
          endcase
        end else begin
          phase_n = PH_WAIT;
        end
      end
    endcase

    // The publish cycle is the one where sample_valid is high; all axes move together.
    if (state_n == ST_PUBLISH) begin
      sample_valid_n  = 1'b1;
      sample_x_n      = shadow_x_n;
      sample_y_n      = shadow_y_n;
      sample_z_n      = shadow_z_n;
`ifdef ADXL_STATUS_READ_EN
      sample_status_n = shadow_s_n;
`endif
    end else begin
      sample_valid_n  = 1'b0;
    end

    // spi_tx/hold follow the byte state being entered so they are stable before spi_start.
    spi_tx_n      = byte_tx(state_n, POWER_CTL_VALUE);
    spi_hold_cs_n = byte_hold(state_n);
  end

  assign spi_start     = spi_start_r;
  assign spi_tx        = spi_tx_r;
  assign spi_hold_cs   = spi_hold_cs_r;
  assign init_done     = init_done_r;
  assign sample_x      = sample_x_r;
  assign sample_y      = sample_y_r;
  assign sample_z      = sample_z_r;
  assign sample_valid  = sample_valid_r;
  assign sample_missed = sample_missed_r;
`ifdef ADXL_STATUS_READ_EN
  assign sample_status = sample_status_r;
`endif

endmodule

// File: tb/tb_adxl_sampler.sv
// tb_adxl_sampler: randomized self-checking bench for adxl_sampler with a
// behavioural SPI-controller model and a transaction-level reference model.
// Build with ADXL_STATUS_READ_EN defined to exercise the STATUS byte variant.
module tb_adxl_sampler;

  localparam int CLK_F   = 1_000_000;
  localparam int RATE    = 1000;
  localparam int PERIOD  = CLK_F / RATE;
  localparam int STARTUP = 100;
`ifdef ADXL_STATUS_READ_EN
  localparam int BURST = 6;
`else
  localparam int BURST = 5;
`endif

  logic       CLK100MHZ = 1'b0;
  logic       CPU_RESETN;
  logic       enable;
  logic       spi_busy;
  logic       spi_done;
  logic [7:0] spi_rx;
  logic       spi_start;
  logic [7:0] spi_tx;
  logic       spi_hold_cs;
  logic       init_done;
  logic [7:0] sample_x, sample_y, sample_z;
  logic       sample_valid;
  logic       sample_missed;
`ifdef ADXL_STATUS_READ_EN
  logic [7:0] sample_status;
`endif

  adxl_sampler #(
    .CLK_FREQUENCY  (CLK_F),
    .SAMPLE_RATE    (RATE),
    .STARTUP_CYCLES (STARTUP),
    .POWER_CTL_VALUE(8'h02)
  ) dut (
    .CLK100MHZ    (CLK100MHZ),
    .CPU_RESETN   (CPU_RESETN),
    .enable       (enable),
    .spi_busy     (spi_busy),
    .spi_done     (spi_done),
    .spi_rx       (spi_rx),
    .spi_start    (spi_start),
    .spi_tx       (spi_tx),
    .spi_hold_cs  (spi_hold_cs),
    .init_done    (init_done),
    .sample_x     (sample_x),
    .sample_y     (sample_y),
    .sample_z     (sample_z),
    .sample_valid (sample_valid),
    .sample_missed(sample_missed)
`ifdef ADXL_STATUS_READ_EN
    ,
    .sample_status(sample_status)
`endif
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_true(input string name, input bit ok, input int act);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: condition false (value %0d)", name, act);
    end
  endtask

  // Expected byte stream: init write then repeating read bursts.
  function automatic logic [7:0] exp_tx(input bit init_ph, input int p);
    if (init_ph) begin
      if (p == 0) return 8'h0A;
      if (p == 1) return 8'h2D;
      return 8'h02;
    end
    if (p == 0) return 8'h0B;
    if (p == 1) return 8'h08;
    return 8'h00;
  endfunction

  function automatic bit exp_hold(input bit init_ph, input int p);
    if (init_ph) return (p < 2);
    return (p < BURST - 1);
  endfunction

  // Model state shared by the SPI model, the monitor and the stimulus.
  int         busy_len = 16;
  bit         fixed_mode = 1'b0;
  int         cyc = 0;
  bit         in_init = 1'b1;
  int         pos = 0;
  bit         inflight = 1'b0;
  int         cur = 0;
  bit         cur_init = 1'b0;
  logic [7:0] rd [0:3];
  bit         pend_valid = 1'b0, pend_init = 1'b0, init_flag = 1'b0;
  logic [7:0] pub_x = 8'h00, pub_y = 8'h00, pub_z = 8'h00, pub_s = 8'h00;
  bit         burst_active = 1'b0;
  int         last_valid_cyc = -10;
  int         last_rst_cyc = 0;
  int         prev_cmd = -1, prev_miss = -1;
  int         valid_cnt = 0, start_cnt = 0, missed_cnt = 0;

  // SPI controller model: busy for busy_len clocks per byte, then one done pulse.
  initial begin
    spi_busy = 1'b0;
    spi_done = 1'b0;
    spi_rx   = 8'h00;
    forever begin
      @(posedge CLK100MHZ);
      #1;
      if (spi_start === 1'b1) begin
        spi_busy = 1'b1;
        repeat (busy_len) @(posedge CLK100MHZ);
        #1;
        spi_busy = 1'b0;
        spi_done = 1'b1;
        if (fixed_mode && !cur_init) begin
          case (cur)
            2:       spi_rx = 8'h12;
            3:       spi_rx = 8'hFE;
            4:       spi_rx = 8'h40;
            5:       spi_rx = 8'h41;
            default: spi_rx = 8'($urandom);
          endcase
        end else begin
          spi_rx = 8'($urandom);
        end
        @(posedge CLK100MHZ);
        #1;
        spi_done = 1'b0;
      end
    end
  end

  // Compare process: checks every DUT output against the model on each negedge.
  initial begin
    bit exp_valid;
    forever begin
      @(negedge CLK100MHZ);
      cyc++;
      if (!CPU_RESETN) begin
        check_eq("reset_outputs",
                 {23'd0, spi_start, spi_tx, spi_hold_cs, init_done, sample_valid, sample_missed},
                 32'd0);
        check_eq("reset_samples", {8'd0, sample_x, sample_y, sample_z}, 32'd0);
        in_init = 1'b1; pos = 0; inflight = 1'b0;
        pend_valid = 1'b0; pend_init = 1'b0; init_flag = 1'b0;
        pub_x = 8'h00; pub_y = 8'h00; pub_z = 8'h00; pub_s = 8'h00;
        burst_active = 1'b0; last_rst_cyc = cyc; prev_cmd = -1; prev_miss = -1;
      end else begin
        if (!enable) begin
          prev_cmd  = -1;
          prev_miss = -1;
        end
        exp_valid  = pend_valid;
        pend_valid = 1'b0;
        if (pend_init) init_flag = 1'b1;
        pend_init = 1'b0;
        check_eq("sample_valid", {31'd0, sample_valid}, {31'd0, exp_valid});
        if (exp_valid) begin
          pub_x = rd[0]; pub_y = rd[1]; pub_z = rd[2]; pub_s = rd[3];
          last_valid_cyc = cyc; burst_active = 1'b0; valid_cnt++;
        end
        check_eq("sample_xyz", {8'd0, sample_x, sample_y, sample_z}, {8'd0, pub_x, pub_y, pub_z});
`ifdef ADXL_STATUS_READ_EN
        check_eq("sample_status", {24'd0, sample_status}, {24'd0, pub_s});
`endif
        check_eq("init_done", {31'd0, init_done}, {31'd0, init_flag});
        if (sample_missed) begin
          missed_cnt++;
          check_true("missed_window", burst_active || (cyc == last_valid_cyc + 1), cyc);
          if (prev_miss >= 0) check_true("missed_period", ((cyc - prev_miss) % PERIOD) == 0, cyc - prev_miss);
          prev_miss = cyc;
        end
        if (spi_start) begin
          check_true("start_overlap", !inflight, cyc);
          check_eq("byte_tx", {24'd0, spi_tx}, {24'd0, exp_tx(in_init, pos)});
          check_eq("byte_hold", {31'd0, spi_hold_cs}, {31'd0, exp_hold(in_init, pos)});
          if (in_init && pos == 0) check_true("startup_delay", (cyc - last_rst_cyc) > STARTUP, cyc - last_rst_cyc);
          if (!in_init && pos == 0) begin
            check_true("burst_overlap", !burst_active, cyc);
            if (prev_cmd >= 0) check_true("tick_period", ((cyc - prev_cmd) % PERIOD) == 0, cyc - prev_cmd);
            prev_cmd = cyc;
            burst_active = 1'b1;
          end
          cur = pos; cur_init = in_init; inflight = 1'b1; start_cnt++;
          pos++;
          if (in_init && pos == 3) begin
            pos = 0;
            in_init = 1'b0;
          end else if (!in_init && pos == BURST) begin
            pos = 0;
          end
        end else if (inflight) begin
          check_eq("tx_stable", {24'd0, spi_tx}, {24'd0, exp_tx(cur_init, cur)});
          check_eq("hold_stable", {31'd0, spi_hold_cs}, {31'd0, exp_hold(cur_init, cur)});
        end
        if (spi_done && inflight) begin
          inflight = 1'b0;
          if (!cur_init && cur >= 2) rd[cur-2] = spi_rx;
          if (cur_init && cur == 2) pend_init = 1'b1;
          if (!cur_init && cur == BURST - 1) pend_valid = 1'b1;
        end
      end
    end
  end

  task automatic wait_valid(input int target, input int budget, input string name);
    int k = 0;
    while (valid_cnt < target && k < budget) begin
      @(posedge CLK100MHZ);
      #1;
      k++;
    end
    check_true(name, valid_cnt >= target, valid_cnt);
  endtask

  task automatic wait_init(input int budget, input string name);
    int k = 0;
    while (!init_done && k < budget) begin
      @(posedge CLK100MHZ);
      #1;
      k++;
    end
    check_eq(name, {31'd0, init_done}, 32'd1);
  endtask

  task automatic wait_byte(input int idx, input int budget, input string name);
    int k = 0;
    while (!(inflight && !cur_init && cur == idx) && k < budget) begin
      @(posedge CLK100MHZ);
      #1;
      k++;
    end
    check_true(name, k < budget, k);
  endtask

  // Stimulus: init, fixed and random bursts, overrun, enable drop, mid-burst reset.
  initial begin
    int v0, m0, s0;
    for (int i = 0; i < 4; i++) rd[i] = 8'h00;
    CPU_RESETN = 1'b0;
    enable     = 1'b0;
    repeat (5) @(posedge CLK100MHZ);
    #1;
    CPU_RESETN = 1'b1;

    // Init runs with enable low; POWER_CTL write then idle.
    wait_init(2000, "init_timeout");
    check_eq("init_byte_count", start_cnt, 32'd3);
    repeat (500) @(posedge CLK100MHZ);
    #1;
    check_eq("no_burst_while_disabled", start_cnt, 32'd3);

    // Fixed axis values.
    fixed_mode = 1'b1;
    enable     = 1'b1;
    v0 = valid_cnt;
    wait_valid(v0 + 2, 4 * PERIOD, "fixed_burst_timeout");
    check_eq("fixed_x", {24'd0, sample_x}, 32'h12);
    check_eq("fixed_y", {24'd0, sample_y}, 32'hFE);
    check_eq("fixed_z", {24'd0, sample_z}, 32'h40);
`ifdef ADXL_STATUS_READ_EN
    check_eq("fixed_status", {24'd0, sample_status}, 32'h41);
`endif
    check_eq("fixed_byte_count", start_cnt, 32'(3 + 2 * BURST));

    // Random axis values.
    fixed_mode = 1'b0;
    wait_valid(v0 + 5, 5 * PERIOD, "random_burst_timeout");
    check_eq("no_missed_at_normal_rate", missed_cnt, 32'd0);

    // Slow controller: bursts outlast the sample period.
    busy_len = 300;
    m0 = missed_cnt;
    v0 = valid_cnt;
    repeat (8000) @(posedge CLK100MHZ);
    #1;
    busy_len = 16;
    check_true("overrun_missed_seen", missed_cnt > m0, missed_cnt - m0);
    check_true("overrun_bursts_done", valid_cnt > v0, valid_cnt - v0);

    // Drop enable while Y is in flight: burst still publishes, then silence.
    wait_byte(3, 6 * PERIOD, "wait_r_y_timeout");
    enable = 1'b0;
    v0 = valid_cnt;
    wait_valid(v0 + 1, 2000, "disable_publish_timeout");
    s0 = start_cnt;
    repeat (3 * PERIOD) @(posedge CLK100MHZ);
    #1;
    check_eq("no_start_after_disable", start_cnt, s0);

    // Reset pulse during the address byte.
    enable = 1'b1;
    wait_byte(1, 3 * PERIOD, "wait_r_addr_timeout");
    CPU_RESETN = 1'b0;
    #1;
    check_eq("reset_immediate", {29'd0, spi_start, spi_hold_cs, init_done}, 32'd0);
    check_eq("reset_immediate_samples", {8'd0, sample_x, sample_y, sample_z}, 32'd0);
    repeat (3) @(posedge CLK100MHZ);
    #1;
    CPU_RESETN = 1'b1;
    s0 = start_cnt;
    wait_init(2000, "reinit_timeout");
    check_eq("reinit_byte_count", start_cnt, s0 + 3);
    v0 = valid_cnt;
    wait_valid(v0 + 1, 3 * PERIOD, "post_reset_burst_timeout");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
